// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Define DATA_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module data_cache #(
  parameter int SETS       = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Pick the addressed byte/half from a word and extend it as funct3 asks.
  function automatic logic [31:0] load_align(input logic [31:0] w,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (f3)
      3'b000:  s = 4'b0001 << off;
      3'b001:  s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      3'b000:  d = {4{wd[7:0]}};
      3'b001:  d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic                    mem_req_q;
  logic                    mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]              mem_wstrb_q, mem_wstrb_d;

  logic [SETS-1:0]         valid_q;
  logic [TAG_W-1:0]        tag_q  [SETS];
  logic [DATA_WIDTH-1:0]   data_q [SETS];

  logic [IDX_W-1:0]        idx_s;
  logic [TAG_W-1:0]        tag_s;
  logic                    hit_s;
  logic [DATA_WIDTH-1:0]   line_s;
  logic                    fill_s;
  logic                    upd_s;

  assign idx_s  = cpu_addr[IDX_W+1:2];
  assign tag_s  = cpu_addr[DATA_WIDTH-1:IDX_W+2];
  assign hit_s  = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign line_s = data_q[idx_s];

  // Next-state, CPU-side outputs and memory-request setup.
  always_comb begin
    state_d     = state_q;
    cpu_stall   = 1'b0;
    cpu_rdata   = 32'h00000000;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    fill_s      = 1'b0;
    upd_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req && cpu_we) begin
          cpu_stall   = 1'b1;
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_addr_d  = {cpu_addr[DATA_WIDTH-1:2], 2'b00};
          mem_wdata_d = store_data(cpu_funct3, cpu_wdata);
          mem_wstrb_d = store_strb(cpu_funct3, cpu_addr[1:0]);
        end else if (cpu_req && hit_s) begin
          cpu_rdata = load_align(line_s, cpu_funct3, cpu_addr[1:0]);
        end else if (cpu_req) begin
          cpu_stall   = 1'b1;
          state_d     = FILL;
          mem_we_d    = 1'b0;
          mem_addr_d  = {cpu_addr[DATA_WIDTH-1:2], 2'b00};
          mem_wstrb_d = 4'hF;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        cpu_stall = 1'b1;
        if (mem_ack) begin
          fill_s  = 1'b1;
          state_d = RESP;
        end else begin
          state_d = FILL;
        end
      end
      WRITE: begin
        cpu_stall = 1'b1;
        // The CPU holds its request, so the hit check is still valid at ack time.
        if (mem_ack) begin
          upd_s   = hit_s;
          state_d = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      RESP: begin
        cpu_rdata = cpu_we ? 32'h00000000 : load_align(line_s, cpu_funct3, cpu_addr[1:0]);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h00000000;
      mem_wdata_q <= 32'h00000000;
      mem_wstrb_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= (state_d == FILL) || (state_d == WRITE);
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // Valid bits are the only array state that resets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= {SETS{1'b0}};
    end else if (fill_s) begin
      valid_q[idx_s] <= 1'b1;
    end
  end

  // Tag/data arrays: line fill on load miss, byte merge on store hit.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_q[idx_s]  <= tag_s;
      data_q[idx_s] <= mem_rdata;
    end else if (upd_s) begin
      data_q[idx_s] <= merge_bytes(data_q[idx_s], mem_wdata_q, mem_wstrb_q);
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        load_idle_s;

  assign load_idle_s = (state_q == IDLE) && cpu_req && !cpu_we;

  // Saturating load hit/miss counters; stores are not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= 32'h00000000;
      miss_cnt_q <= 32'h00000000;
    end else begin
      if (load_idle_s && hit_s && (hit_cnt_q != 32'hFFFFFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (load_idle_s && !hit_s && (miss_cnt_q != 32'hFFFFFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed vector table, reset-during-fill
// sequence, and randomized traffic against a byte-addressed memory model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [2:0]  cpu_funct3 = 3'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_cache #(.SETS(64), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_funct3 (cpu_funct3),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One CPU access from a negedge; plays the memory side with an ack n cycles after mem_req.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input int n, input logic [31:0] mrd,
                        output logic [31:0] rd, output int stalls, output logic sawreq,
                        output logic [31:0] maddr, output logic [31:0] mwd,
                        output logic [3:0] mstrb, output logic mwe,
                        output logic unstable, output logic done);
    int reqcyc;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_funct3 = f3;
    rd = 32'h0; stalls = 0; sawreq = 1'b0; maddr = 32'h0; mwd = 32'h0; mstrb = 4'h0;
    mwe = 1'b0; unstable = 1'b0; done = 1'b0; reqcyc = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      mem_ack = 1'b0;
      #1;
      if (mem_req) begin
        if (!sawreq) begin
          sawreq = 1'b1; maddr = mem_addr; mwd = mem_wdata; mstrb = mem_wstrb; mwe = mem_we;
          reqcyc = 0;
        end else begin
          reqcyc++;
          if (mem_addr !== maddr || mem_wdata !== mwd || mem_wstrb !== mstrb || mem_we !== mwe)
            unstable = 1'b1;
        end
        if (reqcyc == n) begin
          mem_ack = 1'b1; mem_rdata = mrd;
        end
      end
      if (cpu_stall === 1'b0) begin
        rd = cpu_rdata; done = 1'b1;
      end else begin
        stalls++;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    cpu_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    int          n;
    logic [31:0] mrd;
    logic [31:0] exp_rd;
    int          exp_stalls;
    logic        exp_req;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vt[$];

  // Reference model: byte-addressed backing memory and the word address held per set.
  logic [7:0]  bmem  [logic [31:0]];
  logic [31:0] cline [int];

  task automatic touch(input logic [31:0] wa);
    for (int k = 0; k < 4; k++)
      if (!bmem.exists(wa + k)) bmem[wa + k] = 8'($urandom_range(0, 255));
  endtask

  function automatic logic [31:0] mword(input logic [31:0] wa);
    return {bmem[wa + 3], bmem[wa + 2], bmem[wa + 1], bmem[wa]};
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] ha;
    logic [7:0]  b;
    logic [15:0] h;
    ha = a & 32'hFFFF_FFFE;
    b  = bmem[a];
    h  = {bmem[ha + 1], bmem[ha]};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return mword(a & 32'hFFFF_FFFC);
    endcase
  endfunction

  logic [31:0] rd, maddr, mwd, a, wa, wd, ev, ewd;
  logic [3:0]  mstrb, estrb;
  logic        sawreq, mwe, unstable, done, we, hit;
  logic [2:0]  f3;
  int          stalls, n, idx, base, len;
  logic [2:0]  f3_pool [8];

  initial begin
    f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    //            we    addr          wd            f3    n  mrd           exp_rd        st req maddr       strb   exp_wd
    vt.push_back('{1'b0, 32'h100, 32'h0,        3'd2, 3, 32'hDEADBEEF, 32'hDEADBEEF, 5, 1'b1, 32'h100, 4'hF, 32'h0});
    vt.push_back('{1'b0, 32'h100, 32'h0,        3'd2, 1, 32'h0,        32'hDEADBEEF, 0, 1'b0, 32'h0,   4'h0, 32'h0});
    vt.push_back('{1'b0, 32'h103, 32'h0,        3'd0, 1, 32'h0,        32'hFFFFFFDE, 0, 1'b0, 32'h0,   4'h0, 32'h0});
    vt.push_back('{1'b0, 32'h103, 32'h0,        3'd4, 1, 32'h0,        32'h000000DE, 0, 1'b0, 32'h0,   4'h0, 32'h0});
    vt.push_back('{1'b0, 32'h102, 32'h0,        3'd1, 1, 32'h0,        32'hFFFFDEAD, 0, 1'b0, 32'h0,   4'h0, 32'h0});
    vt.push_back('{1'b0, 32'h100, 32'h0,        3'd5, 1, 32'h0,        32'h0000BEEF, 0, 1'b0, 32'h0,   4'h0, 32'h0});
    vt.push_back('{1'b1, 32'h101, 32'h55,       3'd0, 1, 32'h0,        32'h0,        3, 1'b1, 32'h100, 4'h2, 32'h55555555});
    vt.push_back('{1'b0, 32'h100, 32'h0,        3'd2, 1, 32'h0,        32'hDEAD55EF, 0, 1'b0, 32'h0,   4'h0, 32'h0});
    vt.push_back('{1'b0, 32'h200, 32'h0,        3'd2, 2, 32'h12345678, 32'h12345678, 4, 1'b1, 32'h200, 4'hF, 32'h0});
    vt.push_back('{1'b0, 32'h100, 32'h0,        3'd2, 1, 32'hDEAD55EF, 32'hDEAD55EF, 3, 1'b1, 32'h100, 4'hF, 32'h0});
    vt.push_back('{1'b1, 32'h206, 32'hABCD,     3'd1, 1, 32'h0,        32'h0,        3, 1'b1, 32'h204, 4'hC, 32'hABCDABCD});
    vt.push_back('{1'b0, 32'h204, 32'h0,        3'd2, 1, 32'hABCD0000, 32'hABCD0000, 3, 1'b1, 32'h204, 4'hF, 32'h0});
    vt.push_back('{1'b0, 32'h103, 32'h0,        3'd2, 1, 32'h0,        32'hDEAD55EF, 0, 1'b0, 32'h0,   4'h0, 32'h0});
    vt.push_back('{1'b0, 32'h101, 32'h0,        3'd3, 1, 32'h0,        32'hDEAD55EF, 0, 1'b0, 32'h0,   4'h0, 32'h0});
    vt.push_back('{1'b1, 32'h100, 32'h11223344, 3'd7, 1, 32'h0,        32'h0,        3, 1'b1, 32'h100, 4'hF, 32'h11223344});
    vt.push_back('{1'b0, 32'h100, 32'h0,        3'd2, 1, 32'h0,        32'h11223344, 0, 1'b0, 32'h0,   4'h0, 32'h0});
    vt.push_back('{1'b1, 32'h103, 32'h9999,     3'd1, 2, 32'h0,        32'h0,        4, 1'b1, 32'h100, 4'hC, 32'h99999999});
    vt.push_back('{1'b0, 32'h100, 32'h0,        3'd2, 1, 32'h0,        32'h99993344, 0, 1'b0, 32'h0,   4'h0, 32'h0});

    repeat (3) @(negedge clk);
    #1;
    check("reset_mem_req", {31'h0, mem_req}, 32'h0);
    check("reset_stall", {31'h0, cpu_stall}, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      access(vt[i].we, vt[i].addr, vt[i].wd, vt[i].f3, vt[i].n, vt[i].mrd,
             rd, stalls, sawreq, maddr, mwd, mstrb, mwe, unstable, done);
      check($sformatf("vec%0d_done", i), {31'h0, done}, 32'h1);
      check($sformatf("vec%0d_stalls", i), stalls, vt[i].exp_stalls);
      check($sformatf("vec%0d_memreq", i), {31'h0, sawreq}, {31'h0, vt[i].exp_req});
      if (!vt[i].we) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      if (vt[i].exp_req) begin
        check($sformatf("vec%0d_maddr", i), maddr, vt[i].exp_maddr);
        check($sformatf("vec%0d_wstrb", i), {28'h0, mstrb}, {28'h0, vt[i].exp_strb});
        check($sformatf("vec%0d_we", i), {31'h0, mwe}, {31'h0, vt[i].we});
        check($sformatf("vec%0d_stable", i), {31'h0, unstable}, 32'h0);
        if (vt[i].we) check($sformatf("vec%0d_wdata", i), mwd, vt[i].exp_wd);
      end
`ifdef DATA_CACHE_STATS_EN
      if (i == 5) begin
        check("stats_hit", hit_count, 32'd5);
        check("stats_miss", miss_count, 32'd1);
      end
`endif
    end

    // Stray ack while idle must not start anything.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stray_ack_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);

    // Reset in the middle of a fill, then a late ack.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300; cpu_funct3 = 3'd2;
    repeat (3) @(negedge clk);
    #1;
    check("fill_req_seen", {31'h0, mem_req}, 32'h1);
    rst = 1'b0; cpu_req = 1'b0;
    #1;
    check("rst_fill_req", {31'h0, mem_req}, 32'h0);
    check("rst_fill_stall", {31'h0, cpu_stall}, 32'h0);
    check("rst_fill_addr", mem_addr, 32'h0);
    check("rst_fill_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("late_ack_req", {31'h0, mem_req}, 32'h0);
    check("late_ack_stall", {31'h0, cpu_stall}, 32'h0);
    @(negedge clk);
    access(1'b0, 32'h100, 32'h0, 3'd2, 1, 32'h99993344, rd, stalls, sawreq, maddr, mwd, mstrb, mwe, unstable, done);
    check("post_rst_stalls", stalls, 3);
    check("post_rst_rdata", rd, 32'h99993344);

    // Randomized traffic against the memory model.
    cline.delete();
    for (int t = 0; t < 400; t++) begin
      a  = 32'h1000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 7)) << 2)
           + 32'($urandom_range(0, 3));
      wa = a & 32'hFFFF_FFFC;
      idx = int'(wa[7:2]);
      f3 = f3_pool[$urandom_range(0, 7)];
      we = ($urandom_range(0, 2) == 0);
      n  = $urandom_range(1, 4);
      wd = $urandom;
      touch(wa);
      if (!we) begin
        hit = cline.exists(idx) && (cline[idx] == wa);
        ev  = exp_load(a, f3);
        access(1'b0, a, 32'h0, f3, n, mword(wa), rd, stalls, sawreq, maddr, mwd, mstrb, mwe, unstable, done);
        check($sformatf("rnd%0d_load_data", t), rd, ev);
        check($sformatf("rnd%0d_load_stalls", t), stalls, hit ? 0 : n + 2);
        if (!hit) begin
          check($sformatf("rnd%0d_fill_addr", t), maddr, wa);
          check($sformatf("rnd%0d_fill_strb", t), {28'h0, mstrb}, 32'hF);
        end
        cline[idx] = wa;
      end else begin
        if (f3 == 3'd0) begin base = int'(a); len = 1; end
        else if (f3 == 3'd1) begin base = int'(a & 32'hFFFF_FFFE); len = 2; end
        else begin base = int'(wa); len = 4; end
        estrb = 4'h0;
        for (int k = 0; k < len; k++) begin
          bmem[32'(base + k)] = wd[8*k +: 8];
          estrb[base + k - int'(wa)] = 1'b1;
        end
        ewd = (len == 1) ? {4{wd[7:0]}} : (len == 2) ? {2{wd[15:0]}} : wd;
        access(1'b1, a, wd, f3, n, 32'h0, rd, stalls, sawreq, maddr, mwd, mstrb, mwe, unstable, done);
        check($sformatf("rnd%0d_store_stalls", t), stalls, n + 2);
        check($sformatf("rnd%0d_store_addr", t), maddr, wa);
        check($sformatf("rnd%0d_store_strb", t), {28'h0, mstrb}, {28'h0, estrb});
        check($sformatf("rnd%0d_store_wdata", t), mwd, ewd);
        check($sformatf("rnd%0d_store_stable", t), {31'h0, unstable}, 32'h0);
      end
      if ($urandom_range(0, 15) == 0) begin
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check($sformatf("rnd%0d_stray_ack", t), {31'h0, mem_req}, 32'h0);
        @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
